// File: rtl/logic_unit_pkg.sv
// Shared types and op-code helpers for the registered bitwise logic unit.
package logic_unit_pkg;

    // Run-time operation codes; 6 and 7 are reserved and flag an error.
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    // Base-operation class shared by an op and its inverted twin.
    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    function automatic base_e base_of(input op_e op);
        case (op)
            OP_AND, OP_NAND: base_of = BASE_AND;
            OP_OR,  OP_NOR:  base_of = BASE_OR;
            OP_XOR, OP_XNOR: base_of = BASE_XOR;
            default:         base_of = BASE_AND;
        endcase
    endfunction

    function automatic logic is_inv(input op_e op);
        is_inv = (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic is_rsv(input op_e op);
        is_rsv = (op == OP_RSV6) || (op == OP_RSV7);
    endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit base operation (AND / OR / XOR) of two operands.
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [1:0]       i_base,
    output logic [WIDTH-1:0] o_z
);

    base_e w_base;
    assign w_base = base_e'(i_base);

    // Select the bitwise base operation.
    always_comb begin
        o_z = '0;
        case (w_base)
            BASE_AND: o_z = i_x & i_y;
            BASE_OR:  o_z = i_x | i_y;
            BASE_XOR: o_z = i_x ^ i_y;
            default:  o_z = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with multi-beat frame folding and
// valid/ready handshakes on both sides.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_err
);

    state_e           r_state;
    state_e           w_state_nxt;
    op_e              r_op;
    logic [WIDTH-1:0] r_acc;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_y;
    logic             r_out_zero;
    logic             r_out_ones;
    logic             r_out_err;

    op_e              w_op;
    base_e            w_base;
    logic             w_inv;
    logic             w_rsv;
    logic [WIDTH-1:0] w_beat_raw;
    logic [WIDTH-1:0] w_beat;
    logic [WIDTH-1:0] w_fold;
    logic [WIDTH-1:0] w_final;
    logic [WIDTH-1:0] w_res;
    logic             w_xfer;
    logic             w_emit;

    // The op is taken from the input on a frame's first beat, then from the latch.
    assign w_op   = (r_state == ST_IDLE) ? op_e'(in_op) : r_op;
    assign w_base = base_of(w_op);
    assign w_inv  = is_inv(w_op);
    assign w_rsv  = is_rsv(w_op);

    logic_op_core #(.WIDTH(WIDTH)) u_beat (
        .i_x    (in_a),
        .i_y    (in_b),
        .i_base (w_base),
        .o_z    (w_beat_raw)
    );

    // A reserved op forces every per-beat partial to zero.
    assign w_beat = w_rsv ? '0 : w_beat_raw;

    logic_op_core #(.WIDTH(WIDTH)) u_fold (
        .i_x    (r_acc),
        .i_y    (w_beat),
        .i_base (w_base),
        .o_z    (w_fold)
    );

    assign w_final = (r_state == ST_ACCUM) ? w_fold : w_beat;
    assign w_res   = w_rsv ? '0 : (w_inv ? ~w_final : w_final);

    assign in_ready = !r_out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;
    assign w_emit   = w_xfer && in_last;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state: open a frame on a non-last beat, close it on the last.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_xfer && !in_last) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_emit)             w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Accumulator and latched op for frames longer than one beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_op  <= OP_AND;
        end else if (w_xfer && !in_last) begin
            r_acc <= w_final;
            if (r_state == ST_IDLE) r_op <= w_op;
        end
    end

    // Output register: load on an emitted result, clear once accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_zero  <= 1'b0;
            r_out_ones  <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_y     <= w_res;
            r_out_zero  <= (w_res == '0);
            r_out_ones  <= (w_res == '1);
            r_out_err   <= w_rsv;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_zero  = r_out_zero;
    assign out_ones  = r_out_ones;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed cases with literal
// expectations, then randomized traffic against a frame-level model.
module tb_logic_unit_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic         out_zero;
    logic         out_ones;
    logic         out_err;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: pending output plus the beats of the open frame.
    bit           m_known = 0;
    bit           m_valid = 0;
    logic [W-1:0] m_y = '0;
    bit           m_zero = 0;
    bit           m_ones = 0;
    bit           m_err = 0;
    bit           m_in_frame = 0;
    int           m_op = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    task automatic check1(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Result of a whole frame: combine every beat's a/b pair and fold all
    // pairs with the op's base function, then invert for codes 3..5.
    function automatic logic [W-1:0] frame_result(input int op);
        int unsigned  base = op % 3;
        logic [W-1:0] acc  = (base == 0) ? {W{1'b1}} : {W{1'b0}};
        for (int i = 0; i < qa.size(); i++) begin
            case (base)
                0:       acc = acc & qa[i] & qb[i];
                1:       acc = acc | qa[i] | qb[i];
                default: acc = acc ^ qa[i] ^ qb[i];
            endcase
        end
        return (op >= 3) ? ~acc : acc;
    endfunction

    // One clock: check in_ready, advance the model, then check outputs.
    task automatic step();
        bit xfer;
        bit nv;
        int op;
        @(posedge clk);
        if (m_known) check1("in_ready", {7'b0, in_ready}, {7'b0, (!m_valid || out_ready)});
        if (!rst_n) begin
            m_known = 1; m_valid = 0; m_y = '0; m_zero = 0; m_ones = 0; m_err = 0;
            m_in_frame = 0; qa.delete(); qb.delete();
        end else begin
            xfer = in_valid && (!m_valid || out_ready);
            nv   = m_valid && !out_ready;
            if (xfer) begin
                op = m_in_frame ? m_op : int'(in_op);
                qa.push_back(in_a);
                qb.push_back(in_b);
                if (in_last) begin
                    if (op >= 6) begin m_y = '0; m_err = 1; end
                    else begin m_y = frame_result(op); m_err = 0; end
                    m_zero = (m_y == '0);
                    m_ones = (m_y == {W{1'b1}});
                    nv = 1;
                    m_in_frame = 0; qa.delete(); qb.delete();
                end else begin
                    m_in_frame = 1;
                    m_op = op;
                end
            end
            m_valid = nv;
        end
        #1;
        if (m_known) begin
            check1("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
            check1("out_y", out_y, m_y);
            check1("out_zero", {7'b0, out_zero}, {7'b0, m_zero});
            check1("out_ones", {7'b0, out_ones}, {7'b0, m_ones});
            check1("out_err", {7'b0, out_err}, {7'b0, m_err});
        end
    endtask

    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input logic last);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_last = last;
        step();
    endtask

    logic [W-1:0] exp_single [6] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_last = 1'b0; out_ready = 1'b1;
        step();
        step();
        check1("rst_valid", {7'b0, out_valid}, 8'h00);
        check1("rst_y", out_y, 8'h00);
        rst_n = 1'b1;
        step();
        check1("rst_in_ready", {7'b0, in_ready}, 8'h01);

        // Single-beat, all six ops back to back.
        for (int i = 0; i < 6; i++) begin
            beat(8'hF0, 8'h3C, 3'(i), 1'b1);
            check1("single_y", out_y, exp_single[i]);
            check1("single_valid", {7'b0, out_valid}, 8'h01);
        end

        // 3-beat AND frame; later op codes are ignored.
        beat(8'hFF, 8'hF7, 3'd0, 1'b0);
        beat(8'hFE, 8'hFF, 3'd5, 1'b0);
        beat(8'h7F, 8'hFF, 3'd5, 1'b1);
        check1("and3_y", out_y, 8'h76);
        check1("and3_zero", {7'b0, out_zero}, 8'h00);
        check1("and3_ones", {7'b0, out_ones}, 8'h00);

        // 2-beat NOR frame.
        beat(8'h00, 8'h01, 3'd4, 1'b0);
        beat(8'h00, 8'h02, 3'd4, 1'b1);
        check1("nor2_y", out_y, 8'hFC);

        // Flags.
        beat(8'hAA, 8'hAA, 3'd2, 1'b1);
        check1("xor_zero", {7'b0, out_zero}, 8'h01);
        beat(8'hAA, 8'hAA, 3'd5, 1'b1);
        check1("xnor_ones", {7'b0, out_ones}, 8'h01);

        // Backpressure with a new last beat waiting.
        beat(8'h12, 8'h34, 3'd1, 1'b1);
        check1("bp_first", out_y, 8'h36);
        out_ready = 1'b0; in_a = 8'h55; in_b = 8'h0F; in_op = 3'd0; in_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check1("bp_ready", {7'b0, in_ready}, 8'h00);
            check1("bp_hold", out_y, 8'h36);
        end
        out_ready = 1'b1;
        step();
        check1("bp_next_y", out_y, 8'h05);
        check1("bp_next_valid", {7'b0, out_valid}, 8'h01);

        // Reset mid-frame discards the partial frame.
        beat(8'h11, 8'h22, 3'd1, 1'b0);
        beat(8'h33, 8'h44, 3'd1, 1'b0);
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        check1("abort_valid", {7'b0, out_valid}, 8'h00);
        rst_n = 1'b1;
        step();
        check1("abort_ready", {7'b0, in_ready}, 8'h01);
        beat(8'h01, 8'h02, 3'd1, 1'b1);
        check1("abort_or", out_y, 8'h03);

        // Reserved op frame, then a clean frame.
        beat(8'hFF, 8'hFF, 3'd6, 1'b0);
        beat(8'hFF, 8'hFF, 3'd0, 1'b1);
        check1("rsv_y", out_y, 8'h00);
        check1("rsv_err", {7'b0, out_err}, 8'h01);
        beat(8'h0F, 8'hF0, 3'd1, 1'b1);
        check1("post_rsv_y", out_y, 8'hFF);
        check1("post_rsv_err", {7'b0, out_err}, 8'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_op     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            in_last   = ($urandom_range(0, 99) < 35);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
